// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: request field encodings,
// FSM state enum, memory-map defaults and the captured-request record.
package mem_stage_pkg;

  localparam logic [1:0] OP_PASS     = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_STORE    = 2'b10;
  localparam logic [1:0] OP_PASS_ALT = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Idle address sits outside the 4 KiB array so the memory never sees it
  // as a real access; the limit keeps all four bytes of an access in range.
  localparam logic [31:0] PARK_ADDR_DEF  = 32'hFFFF_FFF0;
  localparam logic [31:0] ADDR_LIMIT_DEF = 32'h0000_0FFC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE_RD,
    ST_STORE_GAP,
    ST_STORE_WR,
    ST_RESP
  } state_e;

  // Request fields kept for the life of one in-flight access. For sub-word
  // stores wdata is overwritten with the merged word after the read phase.
  typedef struct packed {
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } mem_req_t;

  // Only loads and stores touch memory; both pass encodings are ALU results.
  function automatic logic is_access(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic for the MEM stage.
//   chk_op/chk_size/chk_addr -> fault : access legality of an incoming request
//   lane_size/lane_uns/rdata -> load_data : extracted, sign/zero-extended load
//   lane_size/rdata/wdata    -> merged : read-modify-write store word
// Lane 0 is always the byte at the access address (little-endian port).
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic [1:0]  chk_op,
  input  logic [1:0]  chk_size,
  input  logic [31:0] chk_addr,
  output logic        fault,
  input  logic [1:0]  lane_size,
  input  logic        lane_uns,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic misalign;

  always_comb begin
    misalign = ((chk_size == SZ_HALF) && chk_addr[0]) ||
               ((chk_size == SZ_WORD) && (chk_addr[1:0] != 2'b00));
    fault    = 1'b0;
    if (is_access(chk_op))
      fault = (chk_size == SZ_ILL) || misalign || (chk_addr > ADDR_LIMIT);
  end

  always_comb begin
    case (lane_size)
      SZ_BYTE: load_data = {{24{~lane_uns & rdata[7]}},  rdata[7:0]};
      SZ_HALF: load_data = {{16{~lane_uns & rdata[15]}}, rdata[15:0]};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    case (lane_size)
      SZ_BYTE: merged = {rdata[31:8],  wdata[7:0]};
      SZ_HALF: merged = {rdata[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: accepts one load/store/pass request from EX at a time,
// drives the shared memory data port and returns one registered result to WB.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   ex_valid/ex_ready                 EX request handshake
//   ex_op/size/unsigned/addr/wdata/rd request fields
//   mem_addr/rw/wdata, mem_rdata      memory data port (rdata combinational)
//   wb_valid/wb_ready                 WB result handshake
//   wb_data/rd/we/fault               registered result
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter logic [31:0] PARK_ADDR  = PARK_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_op,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic [31:0] mem_addr,
  output logic        mem_rw,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        wb_fault
);

  state_e      state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rw_q, mem_rw_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_fault_q, wb_fault_d;

  logic        req_fault;
  logic [31:0] load_data;
  logic [31:0] merged;

  // Fault decode sees the live EX fields; extraction/merge use the captured
  // request against whatever the memory returns this cycle.
  mem_lane_align #(.ADDR_LIMIT(ADDR_LIMIT)) u_lane (
    .chk_op    (ex_op),
    .chk_size  (ex_size),
    .chk_addr  (ex_addr),
    .fault     (req_fault),
    .lane_size (req_q.size),
    .lane_uns  (req_q.uns),
    .rdata     (mem_rdata),
    .wdata     (req_q.wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  assign ex_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    mem_wdata_d = mem_wdata_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_we_d     = wb_we_q;
    wb_fault_d  = wb_fault_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          req_d = '{size: ex_size, uns: ex_unsigned, addr: ex_addr,
                    wdata: ex_wdata, rd: ex_rd};
          wb_rd_d = ex_rd;
          if (!is_access(ex_op)) begin
            state_d    = ST_RESP;
            wb_data_d  = ex_addr;
            wb_we_d    = 1'b1;
            wb_fault_d = 1'b0;
          end else if (req_fault) begin
            state_d    = ST_RESP;
            wb_data_d  = '0;
            wb_we_d    = 1'b0;
            wb_fault_d = 1'b1;
          end else if (ex_op == OP_LOAD) begin
            state_d = ST_LOAD;
          end else if (ex_size == SZ_WORD) begin
            state_d     = ST_STORE_WR;
            mem_wdata_d = ex_wdata;
          end else begin
            state_d = ST_STORE_RD;
          end
        end
      end
      ST_LOAD: begin
        state_d    = ST_RESP;
        wb_data_d  = load_data;
        wb_we_d    = 1'b1;
        wb_fault_d = 1'b0;
      end
      ST_STORE_RD: begin
        // Fold the old word into the store data now; the write phase only
        // has to replay the captured word.
        req_d.wdata = merged;
        state_d     = ST_STORE_GAP;
      end
      ST_STORE_GAP: begin
        state_d     = ST_STORE_WR;
        mem_wdata_d = req_q.wdata;
      end
      ST_STORE_WR: begin
        state_d    = ST_RESP;
        wb_data_d  = '0;
        wb_we_d    = 1'b0;
        wb_fault_d = 1'b0;
      end
      ST_RESP: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Port outputs follow the next state so address, rw and write data all
    // change on the same edge; the memory keys off the address change.
    wb_valid_d = (state_d == ST_RESP);
    mem_rw_d   = (state_d == ST_STORE_WR);
    if ((state_d == ST_LOAD) || (state_d == ST_STORE_RD) || (state_d == ST_STORE_WR))
      mem_addr_d = req_d.addr;
    else
      mem_addr_d = PARK_ADDR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      mem_addr_q  <= PARK_ADDR;
      mem_rw_q    <= 1'b0;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_we_q     <= 1'b0;
      wb_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      mem_addr_q  <= mem_addr_d;
      mem_rw_q    <= mem_rw_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
      wb_fault_q  <= wb_fault_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rw    = mem_rw_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_we     = wb_we_q;
  assign wb_fault  = wb_fault_q;

endmodule
